instruction_fetch: RTL and testbench

- Pipeline stage directly upstream of the decode stage.
- Owns the 24-bit program counter and drives the instruction-memory address. Imem read is combinational: data is valid in the same cycle as the address.
- Captures {pc, instruction, valid} into the IF/ID pipeline register, which feeds decode's inst and pc inputs.
- Handles stall (en), branch redirect/flush from execute, and a HALT instruction via a 3-state FSM.

---
 rtl/instruction_fetch_pkg.sv | 38 +++
 rtl/instruction_fetch_if.sv | 15 +
 rtl/instruction_fetch_buffer.sv | 28 ++
 rtl/instruction_fetch.sv | 108 ++++++++++
 tb/tb_instruction_fetch.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   PC_WIDTH / INST_WIDTH : address and instruction widths
//   NOP_INST              : encoding used for IF/ID bubbles
//   HALT_OPTYPE/OPCODE    : top-six-bit pattern identifying a HALT
//   fetch_state_t         : BOOT -> RUN <-> HALTED
//   if_id_t               : IF/ID pipeline register contents (57 bits)
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int PC_WIDTH   = 24;
  localparam int INST_WIDTH = 32;
  localparam int IF_ID_W    = PC_WIDTH + INST_WIDTH + 1;

  localparam logic [INST_WIDTH-1:0] NOP_INST    = 32'h00000000;
  localparam logic [1:0]            HALT_OPTYPE = 2'b11;
  localparam logic [3:0]            HALT_OPCODE = 4'b1111;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: 24'h000000, inst: NOP_INST, valid: 1'b0};

  // Takes only the instruction's top six bits: {optype[1:0], opcode[3:0]}.
  function automatic logic is_halt(input logic [5:0] top_bits);
    return (top_bits[5:4] == HALT_OPTYPE) && (top_bits[3:0] == HALT_OPCODE);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if: instruction-memory read bus.
//   imemAddr : fetch address (driven by the fetch stage)
//   imemData : instruction at imemAddr, combinational, same cycle
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic [PC_WIDTH-1:0]   imemAddr;
  logic [INST_WIDTH-1:0] imemData;

  modport master (output imemAddr, input  imemData);
  modport slave  (input  imemAddr, output imemData);
endinterface

// File: rtl/instruction_fetch_buffer.sv
// -----------------------------------------------------------------------------
// buffer: generic enabled register, used as the IF/ID pipeline register.
//   clk, rst : rising-edge clock, synchronous active-high reset (clears to 0)
//   en       : 1 = load d_i, 0 = hold
//   d_i/q_o  : Buffer_size-bit data in / registered data out
// -----------------------------------------------------------------------------
module buffer #(
  parameter int Buffer_size = 57
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [Buffer_size-1:0] d_i,
  output logic [Buffer_size-1:0] q_o
);

  // Data register with load enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= '0;
    end else if (en) begin
      q_o <= d_i;
    end else begin
      q_o <= q_o;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch: PC owner and IF/ID register writer.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   en           : 1 = advance, 0 = stall
//   branchTaken  : redirect from execute this cycle
//   branchTarget : redirect address
//   imem         : instruction-memory bus (imemAddr = PC, imemData same cycle)
//   inst/pc/instValid : IF/ID register contents to decode (valid 0 = bubble)
//   halted       : 1 while in HALTED
// -----------------------------------------------------------------------------
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 24'h000000,
  parameter int unsigned         PC_STEP  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   branchTaken,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  instruction_fetch_if.master    imem,
  output logic [INST_WIDTH-1:0]  inst,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   instValid,
  output logic                   halted
);

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                halted_q;
  if_id_t              if_id_d_s, if_id_q_s;
  logic                buf_en_s;
  logic                fetched_halt_s;

  assign fetched_halt_s = is_halt(imem.imemData[INST_WIDTH-1:INST_WIDTH-6]);

  // Next-state, next-PC and IF/ID input mux.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    if_id_d_s = IF_ID_BUBBLE;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (branchTaken) begin
          // Redirect wins over stall and over a HALT fetched this cycle.
          pc_d = branchTarget;
        end else if (!en) begin
          pc_d = pc_q;
        end else begin
          if_id_d_s = '{pc: pc_q, inst: imem.imemData, valid: 1'b1};
          if (fetched_halt_s) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_q + PC_WIDTH'(PC_STEP);
          end
        end
      end
      HALTED: begin
        if (branchTaken) begin
          // An older branch in execute cancels the halt.
          pc_d    = branchTarget;
          state_d = RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // The buffer must load during redirects and outside RUN so bubbles are
  // inserted even when the pipeline is stalled.
  assign buf_en_s = en | branchTaken | (state_q != RUN);

  // FSM state, PC and halted flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == HALTED);
    end
  end

  buffer #(.Buffer_size(IF_ID_W)) u_if_id (
    .clk (clk),
    .rst (rst),
    .en  (buf_en_s),
    .d_i (if_id_d_s),
    .q_o (if_id_q_s)
  );

  assign imem.imemAddr = pc_q;
  assign inst          = if_id_q_s.inst;
  assign pc            = if_id_q_s.pc;
  assign instValid     = if_id_q_s.valid;
  assign halted        = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        branchTaken = 1'b0;
  logic [23:0] branchTarget = 24'h000000;
  logic [31:0] inst;
  logic [23:0] pc;
  logic        instValid;
  logic        halted;

  instruction_fetch_if imem_if ();

  // Word at address 8 is a HALT; every other address holds 0x10000000 + addr.
  function automatic logic [31:0] imem_word(input logic [23:0] a);
    if (a == 24'h000008) return 32'hFC000000;
    return 32'h10000000 + {8'h00, a};
  endfunction

  assign imem_if.imemData = imem_word(imem_if.imemAddr);

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .imem         (imem_if.master),
    .inst         (inst),
    .pc           (pc),
    .instValid    (instValid),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] addr;
    logic [31:0] inst;
    logic [23:0] pc;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic step(input string nm, input logic r, input logic e,
                      input logic b, input logic [23:0] tgt,
                      input logic [23:0] ea, input logic [31:0] ei,
                      input logic [23:0] ep, input logic ev, input logic eh);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; branchTaken = b; branchTarget = tgt;
    x.name = nm; x.addr = ea; x.inst = ei; x.pc = ep; x.valid = ev; x.halted = eh;
    exp_q.push_back(x);
  endtask

  // Monitor: one registered result per edge, checked 1 time unit after it.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_tests++;
      if (imem_if.imemAddr !== x.addr || inst !== x.inst || pc !== x.pc ||
          instValid !== x.valid || halted !== x.halted) begin
        n_fail++;
        $display("FAIL %s: got addr=%h inst=%h pc=%h v=%b h=%b, want addr=%h inst=%h pc=%h v=%b h=%b",
                 x.name, imem_if.imemAddr, inst, pc, instValid, halted,
                 x.addr, x.inst, x.pc, x.valid, x.halted);
      end
    end
  end

  initial begin
    int budget;
    // Reset and boot bubble.
    step("reset",      1'b1, 1'b0, 1'b0, 24'h0, 24'h000000, 32'h00000000, 24'h000000, 1'b0, 1'b0);
    step("boot",       1'b0, 1'b1, 1'b0, 24'h0, 24'h000000, 32'h00000000, 24'h000000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step("seq", 1'b0, 1'b1, 1'b0, 24'h0, 24'(i + 1), 32'h10000000 + 32'(i),
           24'(i), 1'b1, 1'b0);
    end
    // Stall at pc=5.
    for (int i = 0; i < 3; i++) begin
      step("stall",    1'b0, 1'b0, 1'b0, 24'h0, 24'h000006, 32'h10000005, 24'h000005, 1'b1, 1'b0);
    end
    step("resume6",    1'b0, 1'b1, 1'b0, 24'h0, 24'h000007, 32'h10000006, 24'h000006, 1'b1, 1'b0);
    step("seq7",       1'b0, 1'b1, 1'b0, 24'h0, 24'h000008, 32'h10000007, 24'h000007, 1'b1, 1'b0);
    // HALT at address 8.
    step("halt_latch", 1'b0, 1'b1, 1'b0, 24'h0, 24'h000008, 32'hFC000000, 24'h000008, 1'b1, 1'b1);
    step("halt_bub",   1'b0, 1'b1, 1'b0, 24'h0, 24'h000008, 32'h00000000, 24'h000000, 1'b0, 1'b1);
    step("halt_en0",   1'b0, 1'b0, 1'b0, 24'h0, 24'h000008, 32'h00000000, 24'h000000, 1'b0, 1'b1);
    step("halt_br",    1'b0, 1'b1, 1'b1, 24'h000020, 24'h000020, 32'h00000000, 24'h000000, 1'b0, 1'b0);
    step("after_h20",  1'b0, 1'b1, 1'b0, 24'h0, 24'h000021, 32'h10000020, 24'h000020, 1'b1, 1'b0);
    step("after_h21",  1'b0, 1'b1, 1'b0, 24'h0, 24'h000022, 32'h10000021, 24'h000021, 1'b1, 1'b0);
    // Branch during a stall.
    step("br_stall",   1'b0, 1'b0, 1'b1, 24'h000100, 24'h000100, 32'h00000000, 24'h000000, 1'b0, 1'b0);
    step("br_tgt",     1'b0, 1'b1, 1'b0, 24'h0, 24'h000101, 32'h10000100, 24'h000100, 1'b1, 1'b0);
    // Branch in the same cycle a HALT is fetched: branch wins.
    step("br_to8",     1'b0, 1'b1, 1'b1, 24'h000008, 24'h000008, 32'h00000000, 24'h000000, 1'b0, 1'b0);
    step("br_vs_halt", 1'b0, 1'b1, 1'b1, 24'h000030, 24'h000030, 32'h00000000, 24'h000000, 1'b0, 1'b0);
    step("still_run",  1'b0, 1'b1, 1'b0, 24'h0, 24'h000031, 32'h10000030, 24'h000030, 1'b1, 1'b0);
    // PC wrap.
    step("br_top",     1'b0, 1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 32'h00000000, 24'h000000, 1'b0, 1'b0);
    step("wrap_top",   1'b0, 1'b1, 1'b0, 24'h0, 24'h000000, 32'h10FFFFFF, 24'hFFFFFF, 1'b1, 1'b0);
    step("wrap_zero",  1'b0, 1'b1, 1'b0, 24'h0, 24'h000001, 32'h10000000, 24'h000000, 1'b1, 1'b0);
    // Reset while stalled.
    step("pre_rst_st", 1'b0, 1'b0, 1'b0, 24'h0, 24'h000001, 32'h10000000, 24'h000000, 1'b1, 1'b0);
    step("rst_stall",  1'b1, 1'b0, 1'b0, 24'h0, 24'h000000, 32'h00000000, 24'h000000, 1'b0, 1'b0);
    step("reboot",     1'b0, 1'b1, 1'b0, 24'h0, 24'h000000, 32'h00000000, 24'h000000, 1'b0, 1'b0);
    step("reboot_f0",  1'b0, 1'b1, 1'b0, 24'h0, 24'h000001, 32'h10000000, 24'h000000, 1'b1, 1'b0);
    // Reset while halted (branch asserted too: reset still wins).
    step("br_to8b",    1'b0, 1'b1, 1'b1, 24'h000008, 24'h000008, 32'h00000000, 24'h000000, 1'b0, 1'b0);
    step("halt2",      1'b0, 1'b1, 1'b0, 24'h0, 24'h000008, 32'hFC000000, 24'h000008, 1'b1, 1'b1);
    step("rst_halt",   1'b1, 1'b1, 1'b1, 24'h000040, 24'h000000, 32'h00000000, 24'h000000, 1'b0, 1'b0);
    step("boot3",      1'b0, 1'b1, 1'b0, 24'h0, 24'h000000, 32'h00000000, 24'h000000, 1'b0, 1'b0);
    step("boot3_f0",   1'b0, 1'b1, 1'b0, 24'h0, 24'h000001, 32'h10000000, 24'h000000, 1'b1, 1'b0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected results left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
